// File: rtl/reg_alu_sequencer_if.sv
// Instruction handshake and register-file bus of reg_alu_sequencer.
// master = sequencer side, slave = instruction source plus register file.
interface reg_alu_sequencer_if #(
  parameter int unsigned mem_width  = 16,
  parameter int unsigned add_length = 3
);
  logic                  instr_valid;
  logic                  instr_ready;
  logic [2:0]            instr_op;
  logic [add_length-1:0] instr_rd;
  logic [add_length-1:0] instr_rs1;
  logic [add_length-1:0] instr_rs2;
  logic                  rf_ce;
  logic                  rf_rr;
  logic [add_length-1:0] rf_out_data_1_sel;
  logic [add_length-1:0] rf_out_data_2_sel;
  logic [add_length-1:0] rf_in_data_1_sel;
  logic [mem_width-1:0]  rf_in_data_1;
  logic [mem_width-1:0]  rf_out_data_1;
  logic [mem_width-1:0]  rf_out_data_2;

  modport master (
    input  instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2,
    input  rf_out_data_1, rf_out_data_2,
    output instr_ready, rf_ce, rf_rr,
    output rf_out_data_1_sel, rf_out_data_2_sel, rf_in_data_1_sel, rf_in_data_1
  );

  modport slave (
    output instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2,
    output rf_out_data_1, rf_out_data_2,
    input  instr_ready, rf_ce, rf_rr,
    input  rf_out_data_1_sel, rf_out_data_2_sel, rf_in_data_1_sel, rf_in_data_1
  );
endinterface

// File: rtl/reg_alu_sequencer.sv
// Read / execute / write sequencer for an 8x16 dual-read, single-write register file.
// One instruction per handshake; CMP skips the write cycle.
module reg_alu_sequencer #(
  parameter int unsigned mem_width  = 16,
  parameter int unsigned add_length = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  reg_alu_sequencer_if.master   bus,
  output logic [mem_width-1:0]  result,
  output logic                  flag_zero,
  output logic                  flag_carry,
  output logic                  done
);
  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SHL = 3'd5,
    OP_MOV = 3'd6,
    OP_CMP = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_EXEC  = 2'd2,
    S_WRITE = 2'd3
  } state_e;

  state_e                state_q, state_d;
  op_e                   op_q, op_d;
  logic [add_length-1:0] rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic [mem_width-1:0]  result_q, result_d;
  logic                  zero_q, zero_d, carry_q, carry_d, done_q, done_d;
  logic                  ce_c, rr_c;

  logic [mem_width-1:0]  opa, opb, alu_res;
  logic [mem_width:0]    sum, diff;
  logic                  alu_carry;

  assign opa  = bus.rf_out_data_1;
  assign opb  = bus.rf_out_data_2;
  assign sum  = {1'b0, opa} + {1'b0, opb};
  assign diff = {1'b0, opa} - {1'b0, opb};

  // ALU on the operands the register file presents during EXEC
  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    case (op_q)
      OP_ADD: begin
        alu_res   = sum[mem_width-1:0];
        alu_carry = sum[mem_width];
      end
      OP_SUB, OP_CMP: begin
        alu_res   = diff[mem_width-1:0];
        alu_carry = diff[mem_width];
      end
      OP_AND: alu_res = opa & opb;
      OP_OR:  alu_res = opa | opb;
      OP_XOR: alu_res = opa ^ opb;
      OP_SHL: begin
        alu_res   = {opa[mem_width-2:0], 1'b0};
        alu_carry = opa[mem_width-1];
      end
      OP_MOV: alu_res = opa;
      default: alu_res = '0;
    endcase
  end

  // Next-state, capture and Moore decode of the register-file strobes
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rd_d     = rd_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    result_d = result_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    done_d   = 1'b0;
    ce_c     = 1'b0;
    rr_c     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.instr_valid) begin
          op_d    = op_e'(bus.instr_op);
          rd_d    = bus.instr_rd;
          rs1_d   = bus.instr_rs1;
          rs2_d   = bus.instr_rs2;
          state_d = S_READ;
        end
      end
      S_READ: begin
        ce_c    = 1'b1;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        result_d = alu_res;
        zero_d   = (alu_res == '0);
        carry_d  = alu_carry;
        if (op_q == OP_CMP) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        ce_c    = 1'b1;
        rr_c    = 1'b1;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= OP_ADD;
      rd_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      done_q   <= done_d;
    end
  end

  // Chip enable is masked by reset so a reset in WRITE never lands the write
  assign bus.instr_ready       = (state_q == S_IDLE) & rst_n;
  assign bus.rf_ce             = ce_c & rst_n;
  assign bus.rf_rr             = rr_c;
  assign bus.rf_out_data_1_sel = rs1_q;
  assign bus.rf_out_data_2_sel = rs2_q;
  assign bus.rf_in_data_1_sel  = rd_q;
  assign bus.rf_in_data_1      = result_q;

  assign result     = result_q;
  assign flag_zero  = zero_q;
  assign flag_carry = carry_q;
  assign done       = done_q;
endmodule

// File: tb/tb_reg_alu_sequencer.sv
// Bench for reg_alu_sequencer: register-file model, cycle-stamped expectation
// schedule with an arithmetic ALU reference, and directed scenarios with literal results.
module tb_reg_alu_sequencer;
  localparam int unsigned W    = 16;
  localparam int unsigned A    = 3;
  localparam int          NCYC = 1024;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  reg_alu_sequencer_if #(.mem_width(W), .add_length(A)) bus ();
  logic [W-1:0] result;
  logic         flag_zero, flag_carry, done;

  reg_alu_sequencer #(.mem_width(W), .add_length(A)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .result     (result),
    .flag_zero  (flag_zero),
    .flag_carry (flag_carry),
    .done       (done)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Register file: registered reads, write on ce&rr, bus garbage when not freshly read
  logic [W-1:0] rf_mem [8];
  logic [W-1:0] rd1, rd2;
  bit           rd_vld;
  bit           load_en = 1'b0;
  logic [W-1:0] load_r7;

  always @(posedge clk) begin
    rd_vld <= bus.rf_ce && !bus.rf_rr;
    if (bus.rf_ce && !bus.rf_rr) begin
      rd1 <= rf_mem[bus.rf_out_data_1_sel];
      rd2 <= rf_mem[bus.rf_out_data_2_sel];
    end
    if (bus.rf_ce && bus.rf_rr) rf_mem[bus.rf_in_data_1_sel] <= bus.rf_in_data_1;
    if (load_en)
      for (int i = 0; i < 8; i++) rf_mem[i] <= (i == 7) ? load_r7 : W'(i);
  end
  assign bus.rf_out_data_1 = rd_vld ? rd1 : 16'hDEAD;
  assign bus.rf_out_data_2 = rd_vld ? rd2 : 16'hBEEF;

  function automatic logic [W:0] model_alu(input int op, input int a, input int b);
    int r;
    bit c;
    r = 0;
    c = 1'b0;
    case (op)
      0:    begin r = a + b; c = (r >= (1 << W)); end
      1, 7: begin r = a - b; c = (a < b); end
      2:    r = a & b;
      3:    r = a | b;
      4:    r = a ^ b;
      5:    begin r = a * 2; c = (a >= (1 << (W - 1))); end
      6:    r = a;
      default: r = 0;
    endcase
    return {c, W'(r)};
  endfunction

  // Expectation schedule indexed by cycle number; cycle n follows the n-th rising edge
  bit           exp_ce [NCYC];
  bit           exp_rr [NCYC];
  bit           exp_done [NCYC];
  int           busy_until = 0;
  logic [W-1:0] gold [8];
  logic [W-1:0] m_res = '0, p_res, w_val;
  bit           m_z = 1'b0, m_c = 1'b0, p_z, p_c;
  int           p_cyc = -1, wr_cyc = -1;
  logic [A-1:0] t_rd, t_rs1, t_rs2;

  always @(posedge clk) begin : model
    int e;
    logic [W:0] rc;
    if (load_en)
      for (int i = 0; i < 8; i++) gold[i] = (i == 7) ? load_r7 : W'(i);
    if (!rst_n) begin
      for (int i = cyc + 1; i < NCYC; i++) begin
        exp_ce[i] = 1'b0; exp_rr[i] = 1'b0; exp_done[i] = 1'b0;
      end
      busy_until = cyc + 1;
      p_cyc = -1; wr_cyc = -1;
      m_res = '0; m_z = 1'b0; m_c = 1'b0;
    end else begin
      if (cyc == wr_cyc) gold[t_rd] = w_val;
      if (cyc >= busy_until && bus.instr_valid && cyc + 4 < NCYC) begin
        e     = cyc + 1;
        t_rd  = bus.instr_rd;
        t_rs1 = bus.instr_rs1;
        t_rs2 = bus.instr_rs2;
        rc    = model_alu(int'(bus.instr_op), int'(gold[t_rs1]), int'(gold[t_rs2]));
        p_res = rc[W-1:0];
        p_z   = (rc[W-1:0] == '0);
        p_c   = rc[W];
        p_cyc = e + 2;
        exp_ce[e] = 1'b1;
        if (bus.instr_op == 3'd7) begin
          exp_done[e + 2] = 1'b1;
          busy_until = e + 2;
        end else begin
          exp_ce[e + 2]   = 1'b1;
          exp_rr[e + 2]   = 1'b1;
          exp_done[e + 3] = 1'b1;
          busy_until = e + 3;
          wr_cyc = e + 2;
          w_val  = rc[W-1:0];
        end
      end
    end
    cyc++;
    if (p_cyc >= 0 && cyc >= p_cyc) begin
      m_res = p_res; m_z = p_z; m_c = p_c; p_cyc = -1;
    end
  end

  // Per-cycle comparison against the schedule
  always @(negedge clk) begin
    if (cyc >= 1 && cyc < NCYC) begin
      chk("instr_ready", 32'(bus.instr_ready), 32'((cyc >= busy_until) && rst_n));
      chk("rf_ce", 32'(bus.rf_ce), 32'(exp_ce[cyc] && rst_n));
      chk("rf_rr", 32'(bus.rf_rr), 32'(exp_rr[cyc]));
      chk("done", 32'(done), 32'(exp_done[cyc]));
      chk("result", 32'(result), 32'(m_res));
      chk("flag_zero", 32'(flag_zero), 32'(m_z));
      chk("flag_carry", 32'(flag_carry), 32'(m_c));
      if (exp_ce[cyc] && !exp_rr[cyc]) begin
        chk("rd_sel1", 32'(bus.rf_out_data_1_sel), 32'(t_rs1));
        chk("rd_sel2", 32'(bus.rf_out_data_2_sel), 32'(t_rs2));
      end
      if (exp_rr[cyc]) begin
        chk("wr_sel", 32'(bus.rf_in_data_1_sel), 32'(t_rd));
        chk("wr_data", 32'(bus.rf_in_data_1), 32'(w_val));
      end
    end
  end

  task automatic preload(input logic [W-1:0] r7);
    load_r7 = r7;
    load_en = 1'b1;
    @(posedge clk); #1;
    load_en = 1'b0;
  endtask

  task automatic issue(input int op, input int rd, input int rs1, input int rs2);
    bus.instr_op    = 3'(op);
    bus.instr_rd    = A'(rd);
    bus.instr_rs1   = A'(rs1);
    bus.instr_rs2   = A'(rs2);
    bus.instr_valid = 1'b1;
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    bus.instr_op    = 3'($urandom);
    bus.instr_rd    = A'($urandom);
    bus.instr_rs1   = A'($urandom);
    bus.instr_rs2   = A'($urandom);
  endtask

  // Counts cycles from the accept edge to the done cycle (cycle 1 = READ)
  task automatic wait_done(output int n);
    n = 1;
    forever begin
      @(negedge clk);
      if (done) break;
      if (n >= 20) begin
        chk("done_timeout", 32'(0), 32'(1));
        break;
      end
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic lit(input string name, input int r, input logic [W-1:0] res,
                     input bit z, input bit c, input logic [W-1:0] memv);
    chk({name, "_result"}, 32'(result), 32'(res));
    chk({name, "_zero"}, 32'(flag_zero), 32'(z));
    chk({name, "_carry"}, 32'(flag_carry), 32'(c));
    chk({name, "_rf"}, 32'(rf_mem[r]), 32'(memv));
    chk({name, "_model"}, 32'(gold[r]), 32'(memv));
  endtask

  initial begin
    int n;
    rst_n           = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr_op    = '0;
    bus.instr_rd    = '0;
    bus.instr_rs1   = '0;
    bus.instr_rs2   = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_result", 32'(result), 32'(0));
    chk("rst_flags", 32'({flag_zero, flag_carry}), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_ready", 32'(bus.instr_ready), 32'(1));
    chk("rst_ce_rr", 32'({bus.rf_ce, bus.rf_rr}), 32'(0));

    preload(16'h0007);
    issue(0, 3, 5, 6);
    wait_done(n);
    chk("add_latency", 32'(n), 32'(4));
    lit("add", 3, 16'h000B, 1'b0, 1'b0, 16'h000B);

    preload(16'h0007);
    issue(1, 1, 2, 7);
    wait_done(n);
    lit("sub", 1, 16'hFFFB, 1'b0, 1'b1, 16'hFFFB);
    issue(0, 0, 1, 5);
    wait_done(n);
    lit("add_wrap", 0, 16'h0000, 1'b1, 1'b1, 16'h0000);

    preload(16'h0007);
    issue(7, 0, 4, 4);
    wait_done(n);
    chk("cmp_latency", 32'(n), 32'(3));
    lit("cmp", 4, 16'h0000, 1'b1, 1'b0, 16'h0004);
    chk("cmp_r0_kept", 32'(rf_mem[0]), 32'(0));

    preload(16'h0007);
    bus.instr_op = 3'd6; bus.instr_rd = 3'd2; bus.instr_rs1 = 3'd7; bus.instr_rs2 = 3'd0;
    bus.instr_valid = 1'b1;
    @(posedge clk); #1;
    bus.instr_op = 3'd4; bus.instr_rd = 3'd6; bus.instr_rs1 = 3'd2; bus.instr_rs2 = 3'd5;
    wait_done(n);
    chk("b2b_mov_latency", 32'(n), 32'(4));
    chk("b2b_ready_in_done", 32'(bus.instr_ready), 32'(1));
    lit("mov", 2, 16'h0007, 1'b0, 1'b0, 16'h0007);
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    wait_done(n);
    chk("b2b_xor_latency", 32'(n), 32'(4));
    lit("xor", 6, 16'h0002, 1'b0, 1'b0, 16'h0002);

    preload(16'h8001);
    issue(5, 4, 7, 3);
    wait_done(n);
    lit("shl", 4, 16'h0002, 1'b0, 1'b1, 16'h0002);

    preload(16'h0007);
    issue(0, 3, 1, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("abort_done", 32'(done), 32'(0));
    end
    chk("abort_ready", 32'(bus.instr_ready), 32'(1));
    lit("abort", 3, 16'h0000, 1'b0, 1'b0, 16'h0003);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
